// File: rtl/uart_pkg.sv
// Shared UART types: receiver state encoding.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Both flops load RESET_VAL on reset so the output starts at the idle level.
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the asynchronous input through two flops to resolve metastability.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            // NOTE: non-blocking assignments keep this a two-stage pipeline; blocking ones would collapse it to one flop.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_alt_core.sv
// UART 8N1-style receiver: mid-bit sampling from a system-clock cycle counter,
// LSB-first deserialisation, one-entry valid/ready output buffer.
// Optional feature: define UART_RX_ALT_FRAME_ERR_EN to add the err_o
// framing-error pulse port.
module uart_rx_alt_core
    import uart_pkg::*;
#(
    parameter int BAUD_RATE  = 38400,
    parameter int DATA_WIDTH = 8,
    parameter int CLK_SPEED  = 12_000_000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rxd_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i
`ifdef UART_RX_ALT_FRAME_ERR_EN
    ,
    output logic                  err_o
`endif
);

    localparam int CLKS_PER_BIT = CLK_SPEED / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_baud
            $error("uart_rx_alt_core: CLK_SPEED / BAUD_RATE must be at least 4");
        end
    endgenerate

    uart_rx_state_e        state;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  rx_s;

    uart_rx_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk_i),
        .rst (rst_i),
        .d   (rxd_i),
        .q   (rx_s)
    );

    // Receive FSM plus output buffer; every output is a flop, so ready_i has no
    // combinational path to valid_o or data_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
`ifdef UART_RX_ALT_FRAME_ERR_EN
            err_o   <= 1'b0;
`endif
        end else begin
`ifdef UART_RX_ALT_FRAME_ERR_EN
            err_o <= 1'b0;
`endif
            // Consumer takes the held byte; a frame completing this same cycle
            // overrides this below and keeps valid_o high with the new byte.
            if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end

                // Re-check the start bit at its centre to reject short glitches.
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // Bits arrive LSB first, so shift in from the top.
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[DATA_WIDTH-1:1]};
                        if (idx == IDX_LAST) begin
                            state <= STOP;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // Leaving at mid-stop-bit lets the next start edge be caught
                // with only a single stop bit between frames.
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (rx_s) begin
                            // Overrun: a full buffer not being drained keeps its byte.
                            if (!valid_o || ready_i) begin
                                data_o  <= shreg;
                                valid_o <= 1'b1;
                            end
                        end else begin
`ifdef UART_RX_ALT_FRAME_ERR_EN
                            err_o <= 1'b1;
`endif
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_alt_core.sv
// Self-checking bench for uart_rx_alt_core. Runs at a reduced clock so a bit
// is 20 cycles (768100 / 38400, truncated), keeping long strings short in time.
module tb_uart_rx_alt_core;

    localparam int BAUD   = 38400;
    localparam int CLK_HZ = 768_100;
    localparam int DW     = 8;
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int HALF   = CPB / 2;
    localparam int LAT    = 3 + HALF + (DW + 1) * CPB;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          rxd   = 1'b1;
    logic          ready = 1'b0;
    logic [DW-1:0] data;
    logic          valid;
`ifdef UART_RX_ALT_FRAME_ERR_EN
    logic          err;
`endif

    int compared   = 0;
    int mismatched = 0;
    int start_cyc  = 0;

    uart_rx_alt_core #(
        .BAUD_RATE  (BAUD),
        .DATA_WIDTH (DW),
        .CLK_SPEED  (CLK_HZ)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .rxd_i   (rxd),
        .data_o  (data),
        .valid_o (valid),
        .ready_i (ready)
`ifdef UART_RX_ALT_FRAME_ERR_EN
        ,
        .err_o   (err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: log accepted bytes, time valid rises, watch hold stability and err pulses.
    logic [7:0]    got[$];
    int            rise_cyc   = -1;
    int            stab_err   = 0;
    int            err_pulses = 0;
    int            err_long   = 0;
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic          prev_err   = 1'b0;
    logic [DW-1:0] prev_data  = '0;

    always @(negedge clk) begin
        if (valid && ready) got.push_back(data);
        if (valid && !prev_valid) rise_cyc <= cyc;
        if (!rst && prev_valid && !prev_ready && (!valid || data !== prev_data))
            stab_err <= stab_err + 1;
        prev_valid <= valid;
        prev_ready <= ready;
        prev_data  <= data;
`ifdef UART_RX_ALT_FRAME_ERR_EN
        if (err) err_pulses <= err_pulses + 1;
        if (err && prev_err) err_long <= err_long + 1;
        prev_err <= err;
`endif
    end

    task automatic hold_bit(input logic v);
        @(negedge clk);
        rxd = v;
        repeat (CPB - 1) @(negedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        rxd = 1'b1;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rxd       = 1'b0;
        start_cyc = cyc + 1;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < DW; i++) hold_bit(b[i]);
        hold_bit(stop_bit);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        compared++;
        if (valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_valid: got %b want 0", valid);
        end
        compared++;
        if (data !== '0) begin
            mismatched++;
            $display("FAIL reset_data: got %h want 00", data);
        end
`ifdef UART_RX_ALT_FRAME_ERR_EN
        compared++;
        if (err !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_err: got %b want 0", err);
        end
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        int base;
        int lat;
        base = got.size();
        @(posedge clk); #1 ready = 1'b1;
        send_byte(8'h55, 1'b1);
        idle(2 * CPB);
        lat = rise_cyc - start_cyc;
        compared++;
        if (got.size() - base != 1) begin
            mismatched++;
            $display("FAIL single_count: got %0d want 1", got.size() - base);
        end else begin
            compared++;
            if (got[base] !== 8'h55) begin
                mismatched++;
                $display("FAIL single_data: got %h want 55", got[base]);
            end
        end
        compared++;
        if (lat < LAT - 2 || lat > LAT + 2) begin
            mismatched++;
            $display("FAIL single_latency: got %0d want %0d+-2", lat, LAT);
        end
    endtask

    task automatic test_back_to_back();
        string s;
        int    base;
        s    = "$GPVTG,0.00,T,,M,0.00,N,0.00,K,N*32\r\n";
        base = got.size();
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
        idle(3 * CPB);
        compared++;
        if (got.size() - base != s.len()) begin
            mismatched++;
            $display("FAIL b2b_count: got %0d want %0d", got.size() - base, s.len());
        end else begin
            for (int i = 0; i < s.len(); i++) begin
                compared++;
                if (got[base+i] !== s[i]) begin
                    mismatched++;
                    $display("FAIL b2b_byte%0d: got %h want %h", i, got[base+i], s[i]);
                end
            end
            compared++;
            if (got[base] !== 8'h24 || got[base+s.len()-1] !== 8'h0A) begin
                mismatched++;
                $display("FAIL b2b_ends: got %h..%h want 24..0a", got[base], got[base+s.len()-1]);
            end
        end
    endtask

    task automatic test_random_ready();
        logic [7:0] exp_q[$];
        int         base;
        int         stab0;
        bit         done;
        base  = got.size();
        stab0 = stab_err;
        done  = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    logic [7:0] b;
                    b = 8'($urandom);
                    exp_q.push_back(b);
                    send_byte(b, 1'b1);
                end
                idle(3 * CPB);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1 ready = 1'($urandom_range(0, 1));
                end
            end
        join
        @(posedge clk); #1 ready = 1'b1;
        repeat (4) @(negedge clk);
        compared++;
        if (got.size() - base != exp_q.size()) begin
            mismatched++;
            $display("FAIL rand_count: got %0d want %0d", got.size() - base, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                compared++;
                if (got[base+i] !== exp_q[i]) begin
                    mismatched++;
                    $display("FAIL rand_byte%0d: got %h want %h", i, got[base+i], exp_q[i]);
                end
            end
        end
        compared++;
        if (stab_err != stab0) begin
            mismatched++;
            $display("FAIL rand_hold_stable: got %0d changes want 0", stab_err - stab0);
        end
    endtask

    task automatic test_overrun();
        int base;
        int stab0;
        base  = got.size();
        stab0 = stab_err;
        @(posedge clk); #1 ready = 1'b0;
        send_byte(8'h41, 1'b1);
        send_byte(8'h42, 1'b1);
        idle(2 * CPB);
        compared++;
        if (valid !== 1'b1 || data !== 8'h41) begin
            mismatched++;
            $display("FAIL overrun_hold: got valid=%b data=%h want valid=1 data=41", valid, data);
        end
        compared++;
        if (got.size() != base) begin
            mismatched++;
            $display("FAIL overrun_no_xfer: got %0d transfers want 0", got.size() - base);
        end
        @(posedge clk); #1 ready = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if (got.size() - base != 1 || got[got.size()-1] !== 8'h41) begin
            mismatched++;
            $display("FAIL overrun_xfer: got %0d transfers want one of 41", got.size() - base);
        end
        compared++;
        if (valid !== 1'b0) begin
            mismatched++;
            $display("FAIL overrun_valid_clear: got %b want 0", valid);
        end
        compared++;
        if (stab_err != stab0) begin
            mismatched++;
            $display("FAIL overrun_hold_stable: got %0d changes want 0", stab_err - stab0);
        end
    endtask

    task automatic test_glitch();
        int base;
        base = got.size();
        @(negedge clk);
        rxd = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        compared++;
        if (got.size() != base || valid !== 1'b0) begin
            mismatched++;
            $display("FAIL glitch_ignored: got %0d bytes valid=%b want 0 bytes valid=0", got.size() - base, valid);
        end
        send_byte(8'h3C, 1'b1);
        idle(2 * CPB);
        compared++;
        if (got.size() - base != 1 || got[got.size()-1] !== 8'h3C) begin
            mismatched++;
            $display("FAIL glitch_next: got %0d bytes want one of 3c", got.size() - base);
        end
    endtask

    task automatic test_frame_err();
        int base;
        int ep0;
        int el0;
        base = got.size();
        ep0  = err_pulses;
        el0  = err_long;
        send_byte(8'hA5, 1'b0);
        idle(3 * CPB);
        compared++;
        if (got.size() != base || valid !== 1'b0) begin
            mismatched++;
            $display("FAIL ferr_discard: got %0d bytes valid=%b want 0 bytes valid=0", got.size() - base, valid);
        end
`ifdef UART_RX_ALT_FRAME_ERR_EN
        compared++;
        if (err_pulses - ep0 != 1 || err_long != el0) begin
            mismatched++;
            $display("FAIL ferr_pulse: got %0d high cycles (%0d long) want 1", err_pulses - ep0, err_long - el0);
        end
`endif
        send_byte(8'h5A, 1'b1);
        idle(2 * CPB);
        compared++;
        if (got.size() - base != 1 || got[got.size()-1] !== 8'h5A) begin
            mismatched++;
            $display("FAIL ferr_next: got %0d bytes want one of 5a", got.size() - base);
        end
    endtask

    task automatic test_reset_mid_frame();
        int base;
        base = got.size();
        // Data bits 4..7 are 1 so the tail of the aborted frame cannot look like a start bit.
        fork
            send_byte(8'hF3, 1'b1);
            begin
                repeat (5 * CPB + CPB / 2) @(negedge clk);
                rst = 1'b1;
                repeat (2) @(negedge clk);
                compared++;
                if (valid !== 1'b0 || data !== '0) begin
                    mismatched++;
                    $display("FAIL midrst_outputs: got valid=%b data=%h want 0/00", valid, data);
                end
`ifdef UART_RX_ALT_FRAME_ERR_EN
                compared++;
                if (err !== 1'b0) begin
                    mismatched++;
                    $display("FAIL midrst_err: got %b want 0", err);
                end
`endif
                rst = 1'b0;
            end
        join
        idle(2 * CPB);
        compared++;
        if (got.size() != base) begin
            mismatched++;
            $display("FAIL midrst_no_output: got %0d bytes want 0", got.size() - base);
        end
        send_byte(8'hC3, 1'b1);
        idle(2 * CPB);
        compared++;
        if (got.size() - base != 1 || got[got.size()-1] !== 8'hC3) begin
            mismatched++;
            $display("FAIL midrst_next: got %0d bytes want one of c3", got.size() - base);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_random_ready();
        test_overrun();
        test_glitch();
        test_frame_err();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
